// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART command arbiter.
// Command/response widths and the arbiter FSM encoding.
package uart_arb_pkg;

  localparam int CMD_W        = 16;
  localparam int DATA_W       = 8;
  localparam int CMD_READ_BIT = 15;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RSP,
    GAP
  } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin selector.
// Searches from last_grant+1 upward, wrapping modulo NUM_REQ.
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_vld,
  input  logic [IW-1:0]      last_grant,
  output logic [IW-1:0]      win,
  output logic               any
);

  logic [IW-1:0] idx;

  // Walk from farthest to nearest so the nearest request wins.
  always_comb begin
    any = 1'b0;
    win = '0;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IW'((int'(last_grant) + k) % NUM_REQ);
      if (req_vld[idx]) begin
        any = 1'b1;
        win = idx;
      end
    end
  end

endmodule

// File: rtl/uart_cmd_arbiter.sv
// Round-robin arbiter sharing one UART command channel.
// Forwards one command at a time and routes the read response back.
module uart_cmd_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_vld,
  input  logic [CMD_W*NUM_REQ-1:0]   req_cmd,
  output logic [NUM_REQ-1:0]         req_rdy,
  output logic [NUM_REQ-1:0]         rsp_vld,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       rsp_err,
  output logic [CMD_W-1:0]           uart_cmd_in,
  output logic                       uart_cmd_vld,
  input  logic                       uart_cmd_rdy,
  input  logic                       uart_read_rdy,
  input  logic [DATA_W-1:0]          uart_read_data,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);

  arb_state_t state_q, state_d;

  logic [IW-1:0]      last_q, last_d;
  logic [IW-1:0]      gid_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CMD_W-1:0]   cmd_d;
  logic               vld_d;
  logic [NUM_REQ-1:0] req_rdy_d, rsp_vld_d;
  logic [DATA_W-1:0]  rsp_data_d;
  logic               rsp_err_d;
  logic               busy_d;

  logic [IW-1:0]      win;
  logic               any;
  logic [CMD_W-1:0]   cmds [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cmd
    assign cmds[i] = req_cmd[i*CMD_W +: CMD_W];
  end

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_vld    (req_vld),
    .last_grant (last_q),
    .win        (win),
    .any        (any)
  );

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    gid_d      = grant_id;
    cnt_d      = cnt_q;
    cmd_d      = uart_cmd_in;
    vld_d      = uart_cmd_vld;
    req_rdy_d  = '0;
    rsp_vld_d  = '0;
    rsp_data_d = rsp_data;
    rsp_err_d  = rsp_err;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          cmd_d     = cmds[win];
          vld_d     = 1'b1;
          req_rdy_d = NUM_REQ'(1) << win;
          gid_d     = win;
          last_d    = win;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (uart_cmd_vld && uart_cmd_rdy) begin
          vld_d   = 1'b0;
          cnt_d   = '0;
          state_d = uart_cmd_in[CMD_READ_BIT] ? WAIT_RSP : GAP;
        end
      end
      WAIT_RSP: begin
        cnt_d = cnt_q + CW'(1);
        // A response in the timeout cycle still wins.
        if (uart_read_rdy) begin
          rsp_vld_d  = NUM_REQ'(1) << grant_id;
          rsp_data_d = uart_read_data;
          rsp_err_d  = 1'b0;
          state_d    = GAP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rsp_vld_d  = NUM_REQ'(1) << grant_id;
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = GAP;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_q       <= IW'(NUM_REQ - 1);
      grant_id     <= '0;
      cnt_q        <= '0;
      uart_cmd_in  <= '0;
      uart_cmd_vld <= 1'b0;
      req_rdy      <= '0;
      rsp_vld      <= '0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      grant_id     <= gid_d;
      cnt_q        <= cnt_d;
      uart_cmd_in  <= cmd_d;
      uart_cmd_vld <= vld_d;
      req_rdy      <= req_rdy_d;
      rsp_vld      <= rsp_vld_d;
      rsp_data     <= rsp_data_d;
      rsp_err      <= rsp_err_d;
      busy         <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_cmd_arbiter.sv
// Directed self-checking bench for uart_cmd_arbiter.
// NUM_REQ = 4, TIMEOUT = 16.
module tb_uart_cmd_arbiter;

  localparam int N = 4;
  localparam int T = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [N-1:0]  req_vld = '0;
  logic [16*N-1:0] req_cmd = '0;
  logic [N-1:0]  req_rdy;
  logic [N-1:0]  rsp_vld;
  logic [7:0]    rsp_data;
  logic          rsp_err;
  logic [15:0]   uart_cmd_in;
  logic          uart_cmd_vld;
  logic          uart_cmd_rdy = 1'b1;
  logic          uart_read_rdy = 1'b0;
  logic [7:0]    uart_read_data = '0;
  logic          busy;
  logic [1:0]    grant_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_cmd_arbiter #(
    .NUM_REQ (N),
    .TIMEOUT (T)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_vld        (req_vld),
    .req_cmd        (req_cmd),
    .req_rdy        (req_rdy),
    .rsp_vld        (rsp_vld),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err),
    .uart_cmd_in    (uart_cmd_in),
    .uart_cmd_vld   (uart_cmd_vld),
    .uart_cmd_rdy   (uart_cmd_rdy),
    .uart_read_rdy  (uart_read_rdy),
    .uart_read_data (uart_read_data),
    .busy           (busy),
    .grant_id       (grant_id)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output int n);
    n = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (req_rdy != '0) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_vld = '0;
    req_cmd = '0;
    uart_cmd_rdy = 1'b1;
    uart_read_rdy = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (req_rdy !== 4'b0 || rsp_vld !== 4'b0) begin
      errors++;
      $display("FAIL reset_strobes: req_rdy=%b rsp_vld=%b want 0/0", req_rdy, rsp_vld);
    end
    checks++;
    if (rsp_data !== 8'h00 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp: data=%h err=%b want 00/0", rsp_data, rsp_err);
    end
    checks++;
    if (uart_cmd_in !== 16'h0 || uart_cmd_vld !== 1'b0) begin
      errors++;
      $display("FAIL reset_uart: cmd=%h vld=%b want 0000/0", uart_cmd_in, uart_cmd_vld);
    end
    checks++;
    if (busy !== 1'b0 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_busy_gid: busy=%b gid=%0d want 0/0", busy, grant_id);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    int n;
    req_vld = 4'b0100;
    req_cmd[32 +: 16] = 16'h1234;
    uart_cmd_rdy = 1'b1;
    wait_grant(n);
    checks++;
    if (n !== 1) begin
      errors++;
      $display("FAIL sw_latency: cycles=%0d want 1", n);
    end
    checks++;
    if (req_rdy !== 4'b0100 || grant_id !== 2'd2) begin
      errors++;
      $display("FAIL sw_grant: req_rdy=%b gid=%0d want 0100/2", req_rdy, grant_id);
    end
    checks++;
    if (uart_cmd_vld !== 1'b1 || uart_cmd_in !== 16'h1234) begin
      errors++;
      $display("FAIL sw_cmd: vld=%b cmd=%h want 1/1234", uart_cmd_vld, uart_cmd_in);
    end
    req_vld = '0;
    tick();
    checks++;
    if (uart_cmd_vld !== 1'b0 || req_rdy !== 4'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL sw_gap: vld=%b rdy=%b busy=%b want 0/0000/1", uart_cmd_vld, req_rdy, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || rsp_vld !== 4'b0) begin
      errors++;
      $display("FAIL sw_idle: busy=%b rsp_vld=%b want 0/0000", busy, rsp_vld);
    end
  endtask

  task automatic test_round_robin();
    int n;
    logic [3:0] seen;
    logic [15:0] c [4];
    int order [5];
    order = '{0, 1, 2, 3, 0};
    c = '{16'h0100, 16'h0211, 16'h0322, 16'h0433};
    do_reset();
    seen = '0;
    for (int i = 0; i < 4; i++) req_cmd[i*16 +: 16] = c[i];
    req_vld = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_grant(n);
      checks++;
      if (n !== (g == 0 ? 1 : 3)) begin
        errors++;
        $display("FAIL rr_spacing%0d: cycles=%0d want %0d", g, n, (g == 0 ? 1 : 3));
      end
      checks++;
      if (req_rdy !== 4'(1 << order[g]) || grant_id !== 2'(order[g])
          || uart_cmd_in !== c[order[g]]) begin
        errors++;
        $display("FAIL rr_grant%0d: rdy=%b gid=%0d cmd=%h want req %0d cmd %h",
                 g, req_rdy, grant_id, uart_cmd_in, order[g], c[order[g]]);
      end
      if (g < 4) seen = seen | req_rdy;
    end
    checks++;
    if (seen !== 4'b1111) begin
      errors++;
      $display("FAIL rr_fair: seen=%b want 1111", seen);
    end
    req_vld = '0;
    repeat (2) tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rr_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_read();
    int n;
    int bad;
    bad = 0;
    req_vld = 4'b0010;
    req_cmd[16 +: 16] = 16'h8001;
    wait_grant(n);
    checks++;
    if (n < 0 || req_rdy !== 4'b0010 || uart_cmd_in !== 16'h8001) begin
      errors++;
      $display("FAIL rd_grant: n=%0d rdy=%b cmd=%h want 0010/8001", n, req_rdy, uart_cmd_in);
    end
    req_vld = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rsp_vld !== 4'b0) bad++;
    end
    uart_read_rdy = 1'b1;
    uart_read_data = 8'hA5;
    tick();
    uart_read_rdy = 1'b0;
    uart_read_data = 8'h00;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rd_early: rsp_vld seen %0d times want 0", bad);
    end
    checks++;
    if (rsp_vld !== 4'b0010 || rsp_data !== 8'hA5 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL rd_rsp: vld=%b data=%h err=%b want 0010/a5/0", rsp_vld, rsp_data, rsp_err);
    end
    tick();
    checks++;
    if (rsp_vld !== 4'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rd_after: vld=%b busy=%b want 0000/0", rsp_vld, busy);
    end
  endtask

  task automatic test_timeout();
    int n;
    int bad;
    bad = 0;
    req_vld = 4'b1000;
    req_cmd[48 +: 16] = 16'h8042;
    wait_grant(n);
    checks++;
    if (n < 0 || req_rdy !== 4'b1000) begin
      errors++;
      $display("FAIL to_grant: n=%0d rdy=%b want 1000", n, req_rdy);
    end
    req_vld = '0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (rsp_vld !== 4'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL to_early: rsp_vld seen %0d times want 0", bad);
    end
    tick();
    checks++;
    if (rsp_vld !== 4'b1000 || rsp_err !== 1'b1 || rsp_data !== 8'h00) begin
      errors++;
      $display("FAIL to_rsp: vld=%b err=%b data=%h want 1000/1/00", rsp_vld, rsp_err, rsp_data);
    end
    tick();
    uart_read_rdy = 1'b1;
    uart_read_data = 8'h5A;
    tick();
    uart_read_rdy = 1'b0;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (rsp_vld !== 4'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL to_late: stray activity %0d cycles want 0", bad);
    end
  endtask

  task automatic test_backpressure_reset();
    int n;
    int bad;
    bad = 0;
    do_reset();
    uart_cmd_rdy = 1'b0;
    req_vld = 4'b0100;
    req_cmd[32 +: 16] = 16'h8077;
    wait_grant(n);
    checks++;
    if (n < 0 || req_rdy !== 4'b0100 || uart_cmd_vld !== 1'b1) begin
      errors++;
      $display("FAIL bp_grant: n=%0d rdy=%b vld=%b want 0100/1", n, req_rdy, uart_cmd_vld);
    end
    req_vld = '0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (uart_cmd_vld !== 1'b1 || uart_cmd_in !== 16'h8077) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: unstable %0d cycles want 0", bad);
    end
    uart_cmd_rdy = 1'b1;
    tick();
    checks++;
    if (uart_cmd_vld !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_xfer: vld=%b busy=%b want 0/1", uart_cmd_vld, busy);
    end
    tick();
    uart_read_rdy = 1'b1;
    uart_read_data = 8'hFF;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || grant_id !== 2'd0 || uart_cmd_in !== 16'h0
        || rsp_vld !== 4'b0 || rsp_err !== 1'b0 || rsp_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid: busy=%b gid=%0d cmd=%h rsp=%b err=%b data=%h want all 0",
               busy, grant_id, uart_cmd_in, rsp_vld, rsp_err, rsp_data);
    end
    uart_read_rdy = 1'b0;
    for (int i = 0; i < 4; i++) req_cmd[i*16 +: 16] = 16'(16'h0A00 + i);
    req_vld = 4'b1111;
    repeat (2) tick();
    rst_n = 1'b1;
    wait_grant(n);
    checks++;
    if (n !== 1 || req_rdy !== 4'b0001 || grant_id !== 2'd0 || uart_cmd_in !== 16'h0A00) begin
      errors++;
      $display("FAIL rst_regrant: n=%0d rdy=%b gid=%0d cmd=%h want 1/0001/0/0a00",
               n, req_rdy, grant_id, uart_cmd_in);
    end
    req_vld = '0;
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_read();
    test_timeout();
    test_backpressure_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
